// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default VGA 640x480@60 timing constants and window helper
package vga_timing_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int CNT_W     = 10;

    localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    // Half-open window test [lo, hi)
    function automatic logic in_range(input int unsigned pos, input int unsigned lo,
                                      input int unsigned hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/ctrl_circuit_if.sv
// rtl/ctrl_circuit_if.sv - VGA timing outputs bundle (sync, visible flag, coordinates)
interface ctrl_circuit_if #(
    parameter int CNT_W = vga_timing_pkg::CNT_W
);
    logic             HS;
    logic             VS;
    logic             VIDEO_ON;
    logic [CNT_W-1:0] H_CNT;
    logic [CNT_W-1:0] V_CNT;

    modport master (output HS, output VS, output VIDEO_ON, output H_CNT, output V_CNT);
    modport slave  (input  HS, input  VS, input  VIDEO_ON, input  H_CNT, input  V_CNT);
endinterface

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - wrap counter with registered sync-window and visible-window decode
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL      = H_TOTAL,
    parameter int SYNC_START = H_SYNC_START,
    parameter int SYNC_END   = H_SYNC_END,
    parameter int VISIBLE    = H_VISIBLE,
    parameter int W          = CNT_W
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         last_o,
    output logic         sync_n_o,
    output logic         visible_o
);

    localparam logic [W-1:0] LAST        = W'(TOTAL - 1);
    localparam logic         SYNC_N_RST  = !in_range(0, SYNC_START, SYNC_END);
    localparam logic         VISIBLE_RST = in_range(0, 0, VISIBLE);

    logic [W-1:0] cnt_q, cnt_d;
    logic         sync_n_q, sync_n_d;
    logic         visible_q, visible_d;

    assign last_o = (cnt_q == LAST);

    // Decode from the next count so the flags line up with the count they describe
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = last_o ? '0 : cnt_q + 1'b1;
        end
        sync_n_d  = !in_range(32'(cnt_d), SYNC_START, SYNC_END);
        visible_d = in_range(32'(cnt_d), 0, VISIBLE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q     <= '0;
            sync_n_q  <= SYNC_N_RST;
            visible_q <= VISIBLE_RST;
        end else begin
            cnt_q     <= cnt_d;
            sync_n_q  <= sync_n_d;
            visible_q <= visible_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign sync_n_o  = sync_n_q;
    assign visible_o = visible_q;

endmodule

// File: rtl/ctrl_circuit.sv
// rtl/ctrl_circuit.sv - VGA timing controller top; CTRL_CIRCUIT_FRAME_TICK_EN adds FRAME_TICK
module ctrl_circuit #(
    parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BACK    = vga_timing_pkg::H_BACK,
    parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BACK    = vga_timing_pkg::V_BACK,
    parameter int CNT_W     = vga_timing_pkg::CNT_W
) (
    input  logic           PIX_CLK,
    input  logic           RST_N,
`ifdef CTRL_CIRCUIT_FRAME_TICK_EN
    output logic           FRAME_TICK,
`endif
    ctrl_circuit_if.master vga
);

    localparam int H_TOT   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SSTRT = H_VISIBLE + H_FRONT;
    localparam int V_SSTRT = V_VISIBLE + V_FRONT;

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             h_last, v_last;
    logic             h_sync_n, v_sync_n;
    logic             h_vis, v_vis;

    vga_axis_counter #(
        .TOTAL      (H_TOT),
        .SYNC_START (H_SSTRT),
        .SYNC_END   (H_SSTRT + H_SYNC),
        .VISIBLE    (H_VISIBLE),
        .W          (CNT_W)
    ) u_h_axis (
        .clk_i     (PIX_CLK),
        .rst_n_i   (RST_N),
        .en_i      (1'b1),
        .cnt_o     (h_cnt),
        .last_o    (h_last),
        .sync_n_o  (h_sync_n),
        .visible_o (h_vis)
    );

    // The vertical axis advances only on the horizontal wrap edge, so VS is line-granular
    vga_axis_counter #(
        .TOTAL      (V_TOT),
        .SYNC_START (V_SSTRT),
        .SYNC_END   (V_SSTRT + V_SYNC),
        .VISIBLE    (V_VISIBLE),
        .W          (CNT_W)
    ) u_v_axis (
        .clk_i     (PIX_CLK),
        .rst_n_i   (RST_N),
        .en_i      (h_last),
        .cnt_o     (v_cnt),
        .last_o    (v_last),
        .sync_n_o  (v_sync_n),
        .visible_o (v_vis)
    );

    assign vga.HS       = h_sync_n;
    assign vga.VS       = v_sync_n;
    assign vga.VIDEO_ON = h_vis & v_vis;
    assign vga.H_CNT    = h_cnt;
    assign vga.V_CNT    = v_cnt;

`ifdef CTRL_CIRCUIT_FRAME_TICK_EN
    localparam logic [CNT_W-1:0] H_PRE_LAST = CNT_W'(H_TOT - 2);

    logic frame_tick_q, frame_tick_d;

    // Next position is the last pixel of the frame when we sit one pixel before it on the last line
    always_comb begin
        frame_tick_d = v_last && (h_cnt == H_PRE_LAST);
    end

    always_ff @(posedge PIX_CLK) begin
        if (!RST_N) begin
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= frame_tick_d;
        end
    end

    assign FRAME_TICK = frame_tick_q;
`else
    logic unused_v_last;
    assign unused_v_last = v_last;
`endif

endmodule

// File: tb/tb_ctrl_circuit.sv
// tb/tb_ctrl_circuit.sv - scoreboard bench for ctrl_circuit with reduced timing; CTRL_CIRCUIT_FRAME_TICK_EN aware
module tb_ctrl_circuit;

    localparam int HV  = 16;
    localparam int HF  = 4;
    localparam int HSY = 6;
    localparam int HB  = 4;
    localparam int VV  = 12;
    localparam int VF  = 3;
    localparam int VSY = 2;
    localparam int VB  = 4;
    localparam int W   = 10;
    localparam int HT  = HV + HF + HSY + HB;
    localparam int VT  = VV + VF + VSY + VB;

    typedef struct packed {
        logic [W-1:0] h;
        logic [W-1:0] v;
        logic         hs;
        logic         vs;
        logic         von;
        logic         tick;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #20 clk = ~clk;

    ctrl_circuit_if #(.CNT_W(W)) vif ();

`ifdef CTRL_CIRCUIT_FRAME_TICK_EN
    logic frame_tick;
`endif

    ctrl_circuit #(
        .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HSY), .H_BACK (HB),
        .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VSY), .V_BACK (VB),
        .CNT_W     (W)
    ) dut (
        .PIX_CLK    (clk),
        .RST_N      (rst_n),
`ifdef CTRL_CIRCUIT_FRAME_TICK_EN
        .FRAME_TICK (frame_tick),
`endif
        .vga        (vif)
    );

    obs_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   mh = 0;
    int   mv = 0;
    int   edges = 0;

    function automatic obs_t observe();
        obs_t o;
        o.h   = vif.H_CNT;
        o.v   = vif.V_CNT;
        o.hs  = vif.HS;
        o.vs  = vif.VS;
        o.von = vif.VIDEO_ON;
`ifdef CTRL_CIRCUIT_FRAME_TICK_EN
        o.tick = frame_tick;
`else
        o.tick = 1'b0;
`endif
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("h=%0d v=%0d hs=%b vs=%b von=%b tick=%b", o.h, o.v, o.hs, o.vs, o.von, o.tick);
    endfunction

    // Reference position model; pushes the expectation for the coming edge, then clocks
    task automatic drive_cycle(input logic r);
        obs_t e;
        rst_n = r;
        if (!r) begin
            mh = 0;
            mv = 0;
            edges = 0;
        end else begin
            edges++;
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh++;
            end
        end
        e.h   = W'(mh);
        e.v   = W'(mv);
        e.hs  = !(mh >= HV + HF && mh < HV + HF + HSY);
        e.vs  = !(mv >= VV + VF && mv < VV + VF + VSY);
        e.von = (mh < HV) && (mv < VV);
`ifdef CTRL_CIRCUIT_FRAME_TICK_EN
        e.tick = r && (mh == HT - 1) && (mv == VT - 1);
`else
        e.tick = 1'b0;
`endif
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t got, exp;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b0);
            got = observe();
            exp = sb.pop_front();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL reset_hold[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_hs_timing();
        obs_t got, exp;
        logic prev_hs = 1'b1;
        int   first_fall = -1;
        int   second_fall = -1;
        int   low_width = -1;
        for (int i = 0; i < 3 * HT; i++) begin
            drive_cycle(1'b1);
            got = observe();
            exp = sb.pop_front();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL hs_run@%0d: got %s, expected %s", edges, fmt(got), fmt(exp));
            end
            if (prev_hs && !got.hs) begin
                if (first_fall < 0) first_fall = edges;
                else if (second_fall < 0) second_fall = edges;
            end
            if (!prev_hs && got.hs && low_width < 0 && first_fall >= 0) low_width = edges - first_fall;
            prev_hs = got.hs;
        end
        compared++;
        if (first_fall !== HV + HF) begin
            mismatched++;
            $display("FAIL hs_first_fall: got %0d, expected %0d", first_fall, HV + HF);
        end
        compared++;
        if (second_fall - first_fall !== HT) begin
            mismatched++;
            $display("FAIL hs_period: got %0d, expected %0d", second_fall - first_fall, HT);
        end
        compared++;
        if (low_width !== HSY) begin
            mismatched++;
            $display("FAIL hs_width: got %0d, expected %0d", low_width, HSY);
        end
    endtask

    task automatic test_vs_frame_wrap();
        obs_t got, exp;
        logic prev_vs = 1'b1;
        int   vs_fall = -1;
        int   vs_width = -1;
        int   wrap_at = -1;
        int   ticks = 0;
        int   tick_at = -1;
        while (edges < VT * HT + HT) begin
            drive_cycle(1'b1);
            got = observe();
            exp = sb.pop_front();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL frame_run@%0d: got %s, expected %s", edges, fmt(got), fmt(exp));
            end
            if (prev_vs && !got.vs && vs_fall < 0) vs_fall = edges;
            if (!prev_vs && got.vs && vs_fall >= 0 && vs_width < 0) vs_width = edges - vs_fall;
            if (got.h == 0 && got.v == 0 && wrap_at < 0) wrap_at = edges;
            if (got.tick) begin
                ticks++;
                tick_at = edges;
            end
            prev_vs = got.vs;
        end
        compared++;
        if (vs_fall !== (VV + VF) * HT) begin
            mismatched++;
            $display("FAIL vs_fall: got %0d, expected %0d", vs_fall, (VV + VF) * HT);
        end
        compared++;
        if (vs_width !== VSY * HT) begin
            mismatched++;
            $display("FAIL vs_width: got %0d, expected %0d", vs_width, VSY * HT);
        end
        compared++;
        if (wrap_at !== VT * HT) begin
            mismatched++;
            $display("FAIL frame_wrap: got %0d, expected %0d", wrap_at, VT * HT);
        end
`ifdef CTRL_CIRCUIT_FRAME_TICK_EN
        compared++;
        if (ticks !== 1 || tick_at !== VT * HT - 1) begin
            mismatched++;
            $display("FAIL frame_tick: got count=%0d at=%0d, expected count=1 at=%0d", ticks, tick_at, VT * HT - 1);
        end
`else
        compared++;
        if (ticks !== 0) begin
            mismatched++;
            $display("FAIL frame_tick_absent: got %0d, expected 0", ticks);
        end
`endif
    endtask

    task automatic test_mid_reset();
        obs_t got, exp;
        logic found = 1'b0;
        logic prev_hs = 1'b1;
        int   hs_fall = -1;
        for (int i = 0; i < VT * HT && !found; i++) begin
            drive_cycle(1'b1);
            got = observe();
            exp = sb.pop_front();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL pre_reset_run@%0d: got %s, expected %s", edges, fmt(got), fmt(exp));
            end
            if (!got.vs) found = 1'b1;
        end
        compared++;
        if (found !== 1'b1) begin
            mismatched++;
            $display("FAIL vs_low_search: got %b, expected 1", found);
        end
        drive_cycle(1'b0);
        got = observe();
        exp = sb.pop_front();
        compared++;
        if (got !== exp || got.h !== '0 || got.v !== '0 || got.hs !== 1'b1 || got.vs !== 1'b1) begin
            mismatched++;
            $display("FAIL mid_reset: got %s, expected h=0 v=0 hs=1 vs=1 von=1 tick=0", fmt(got));
        end
        for (int i = 0; i < 2 * HT; i++) begin
            drive_cycle(1'b1);
            got = observe();
            exp = sb.pop_front();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL post_reset_run@%0d: got %s, expected %s", edges, fmt(got), fmt(exp));
            end
            if (prev_hs && !got.hs && hs_fall < 0) hs_fall = edges;
            prev_hs = got.hs;
        end
        compared++;
        if (hs_fall !== HV + HF) begin
            mismatched++;
            $display("FAIL restart_hs_fall: got %0d, expected %0d", hs_fall, HV + HF);
        end
    endtask

    task automatic test_back_to_back();
        obs_t got, exp;
        logic prev_vs = 1'b1;
        int   falls = 0;
        int   fall0 = -1;
        int   fall1 = -1;
        int   von_hi = 0;
        for (int i = 0; i < 2 * VT * HT; i++) begin
            drive_cycle(1'b1);
            got = observe();
            exp = sb.pop_front();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL b2b_run@%0d: got %s, expected %s", edges, fmt(got), fmt(exp));
            end
            if (prev_vs && !got.vs) begin
                falls++;
                if (fall0 < 0) fall0 = edges;
                else if (fall1 < 0) fall1 = edges;
            end
            if (got.von) von_hi++;
            prev_vs = got.vs;
        end
        compared++;
        if (falls !== 2 || fall1 - fall0 !== VT * HT) begin
            mismatched++;
            $display("FAIL vs_period: got falls=%0d period=%0d, expected falls=2 period=%0d", falls, fall1 - fall0, VT * HT);
        end
        compared++;
        if (von_hi !== 2 * HV * VV) begin
            mismatched++;
            $display("FAIL video_on_count: got %0d, expected %0d", von_hi, 2 * HV * VV);
        end
    endtask

    initial begin
        test_reset();
        test_hs_timing();
        test_vs_frame_wrap();
        test_mid_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
